mfm_encoder: RTL and testbench

MFM_ENCODER -- requirements
Module: mfm_encoder

---
 rtl/mfm_encoder.sv | 135 +++++++++++++
 tb/tb_mfm_encoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mfm_encoder.sv
// MFM serialiser: 1-byte holding register feeding a 16-cell shifter; first cell two edges after accept, CELL_CLKS clk_50 per cell.
// data_ready = holding register empty; a byte offered on a shifter load edge is taken anyway. MFM_SYNC_MISSING_CLOCK_EN adds sync marks.
module mfm_encoder #(
    parameter int CELL_CLKS = 5
) (
    input  logic       clk_50,
    input  logic       reset_n,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    input  logic       data_sync,
    output logic       data_ready,
    output logic       mfm_out,
    output logic       busy
);

    localparam logic [7:0] PH_LAST = 8'(CELL_CLKS - 1);

    logic        hold_full_q, hold_full_d;
    logic [7:0]  hold_dat_q, hold_dat_d;
    logic        hold_sync_q, hold_sync_d;
    logic [15:0] sh_q, sh_d;
    logic        act_q, act_d;
    logic [7:0]  phase_q, phase_d;
    logic [3:0]  cell_q, cell_d;
    logic        prev_q, prev_d;
    logic        mfm_out_q, busy_q;

    logic        cell_end, last_cyc, load, accept, prev_eff;
    logic [15:0] enc_word, load_word;

    // Clock cell of a 0 bit is set only when the preceding data bit was also 0.
    function automatic logic [15:0] mfm_enc(input logic [7:0] b, input logic p);
        logic [15:0] w;
        logic        prv;
        w   = '0;
        prv = p;
        for (int i = 7; i >= 0; i--) begin
            w[2*i+1] = ~b[i] & ~prv;
            w[2*i]   = b[i];
            prv      = b[i];
        end
        return w;
    endfunction

    assign cell_end = act_q && (phase_q == PH_LAST);
    assign last_cyc = cell_end && (cell_q == 4'd15);
    assign load     = hold_full_q && (!act_q || last_cyc);
    assign accept   = data_valid && (!hold_full_q || load);
    // On a back-to-back reload the last data bit is still in the shifter, not yet in prev_q.
    assign prev_eff = last_cyc ? sh_q[15] : prev_q;
    assign enc_word = mfm_enc(hold_dat_q, prev_eff);

`ifdef MFM_SYNC_MISSING_CLOCK_EN
    assign load_word = hold_sync_q ? (enc_word & 16'hFFDF) : enc_word;
`else
    logic unused_sync;
    assign unused_sync = hold_sync_q;
    assign load_word   = enc_word;
`endif

    always_comb begin
        hold_full_d = hold_full_q;
        hold_dat_d  = hold_dat_q;
        hold_sync_d = hold_sync_q;
        sh_d        = sh_q;
        act_d       = act_q;
        phase_d     = phase_q;
        cell_d      = cell_q;
        prev_d      = prev_q;

        if (act_q) begin
            if (cell_end) begin
                phase_d = '0;
                if (cell_q[0]) begin
                    prev_d = sh_q[15];
                end
                if (cell_q == 4'd15) begin
                    act_d  = 1'b0;
                    sh_d   = '0;
                    cell_d = '0;
                end else begin
                    sh_d   = {sh_q[14:0], 1'b0};
                    cell_d = cell_q + 4'd1;
                end
            end else begin
                phase_d = phase_q + 8'd1;
            end
        end

        if (load) begin
            sh_d        = load_word;
            act_d       = 1'b1;
            phase_d     = '0;
            cell_d      = '0;
            hold_full_d = 1'b0;
        end

        if (accept) begin
            hold_full_d = 1'b1;
            hold_dat_d  = data_in;
            hold_sync_d = data_sync;
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            hold_full_q <= 1'b0;
            hold_dat_q  <= '0;
            hold_sync_q <= 1'b0;
            sh_q        <= '0;
            act_q       <= 1'b0;
            phase_q     <= '0;
            cell_q      <= '0;
            prev_q      <= 1'b0;
            mfm_out_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_dat_q  <= hold_dat_d;
            hold_sync_q <= hold_sync_d;
            sh_q        <= sh_d;
            act_q       <= act_d;
            phase_q     <= phase_d;
            cell_q      <= cell_d;
            prev_q      <= prev_d;
            mfm_out_q   <= act_q & sh_q[15];
            busy_q      <= act_q;
        end
    end

    assign data_ready = ~hold_full_q;
    assign mfm_out    = mfm_out_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mfm_encoder.sv
// Directed bench for mfm_encoder: captures the cell stream while busy and compares it to hand-encoded words.
module tb_mfm_encoder;

    localparam int CC       = 5;
    localparam int BYTE_CYC = 16 * CC;

`ifdef MFM_SYNC_MISSING_CLOCK_EN
    localparam logic [15:0] EXP_SYNC = 16'h4489;
`else
    localparam logic [15:0] EXP_SYNC = 16'h44A9;
`endif

    logic       clk_50     = 1'b0;
    logic       reset_n    = 1'b0;
    logic [7:0] data_in    = '0;
    logic       data_valid = 1'b0;
    logic       data_sync  = 1'b0;
    logic       data_ready;
    logic       mfm_out;
    logic       busy;

    int   checks   = 0;
    int   failures = 0;
    logic cap_en   = 1'b0;
    logic cap_q[$];
    int   runs     = 0;
    logic busy_prev = 1'b0;

    mfm_encoder #(.CELL_CLKS(CC)) dut (
        .clk_50     (clk_50),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_sync  (data_sync),
        .data_ready (data_ready),
        .mfm_out    (mfm_out),
        .busy       (busy)
    );

    always #5 clk_50 = ~clk_50;

    always @(negedge clk_50) begin
        if (cap_en) begin
            if (busy) cap_q.push_back(mfm_out);
            if (busy && !busy_prev) runs++;
        end
        busy_prev = busy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_50);
        #1;
    endtask

    task automatic cap_start;
        cap_q.delete();
        runs   = 0;
        cap_en = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic s, output int waited);
        waited = 0;
        while (!data_ready && waited < 500) begin
            tick;
            waited++;
        end
        if (waited >= 500) check("send_timeout", 32'(data_ready), 32'd1);
        data_in    = b;
        data_sync  = s;
        data_valid = 1'b1;
        tick;
        data_valid = 1'b0;
        data_sync  = 1'b0;
    endtask

    task automatic wait_stream(input string tag);
        int n = 0;
        while (!busy && n < 300) begin
            tick;
            n++;
        end
        while (busy && n < 1500) begin
            tick;
            n++;
        end
        check({tag, "_done"}, 32'(n < 1500 && !busy), 32'd1);
        cap_en = 1'b0;
    endtask

    task automatic check_words(input string tag, input logic [15:0] w0, input logic [15:0] w1,
                               input logic [15:0] w2, input int nw);
        check({tag, "_len"}, 32'(cap_q.size()), 32'(nw * BYTE_CYC));
        check({tag, "_runs"}, 32'(runs), 32'd1);
        if (cap_q.size() == nw * BYTE_CYC) begin
            for (int k = 0; k < nw; k++) begin
                logic [15:0] exp;
                logic [15:0] obs;
                logic        flat;
                exp  = (k == 0) ? w0 : (k == 1) ? w1 : w2;
                obs  = '0;
                flat = 1'b1;
                for (int c = 0; c < 16; c++) begin
                    obs[15-c] = cap_q[k*BYTE_CYC + c*CC + 2];
                    for (int j = 0; j < CC; j++)
                        if (cap_q[k*BYTE_CYC + c*CC + j] !== obs[15-c]) flat = 1'b0;
                end
                check($sformatf("%s_word%0d", tag, k), 32'(obs), 32'(exp));
                check($sformatf("%s_flat%0d", tag, k), 32'(flat), 32'd1);
            end
        end
    endtask

    initial begin
        int   wt;
        int   n;
        logic idle_ok;

        repeat (3) tick;
        check("rst_mfm", 32'(mfm_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdy", 32'(data_ready), 32'd1);
        reset_n = 1'b1;
        tick;

        // 0x00 after reset, plus load/first-cell latency
        cap_start;
        send_byte(8'h00, 1'b0, wt);
        check("acc_rdy", 32'(data_ready), 32'd0);
        tick;
        check("load_busy", 32'(busy), 32'd0);
        check("load_rdy", 32'(data_ready), 32'd1);
        tick;
        check("first_busy", 32'(busy), 32'd1);
        check("first_mfm", 32'(mfm_out), 32'd1);
        wait_stream("b00");
        check_words("b00", 16'hAAAA, 16'h0, 16'h0, 1);

        cap_start;
        send_byte(8'hA1, 1'b1, wt);
        wait_stream("sync1");
        check_words("sync1", EXP_SYNC, 16'h0, 16'h0, 1);

        cap_start;
        send_byte(8'hA1, 1'b0, wt);
        wait_stream("sync0");
        check_words("sync0", 16'h44A9, 16'h0, 16'h0, 1);

        // back-to-back 0xFF then 0x00
        cap_start;
        send_byte(8'hFF, 1'b0, wt);
        send_byte(8'h00, 1'b0, wt);
        check("b2b_rdy_low", 32'(wt), 32'd1);
        check("b2b_rdy_held", 32'(data_ready), 32'd0);
        wait_stream("b2b");
        check_words("b2b", 16'h5555, 16'h2AAA, 16'h0, 2);
        check("b2b_rdy_end", 32'(data_ready), 32'd1);

        // three bytes with data_valid held high
        cap_start;
        data_in    = 8'h0F;
        data_valid = 1'b1;
        tick;
        check("q_rdy_acc", 32'(data_ready), 32'd0);
        data_in = 8'h3C;
        tick;
        check("q_rdy_load", 32'(data_ready), 32'd0);
        data_in = 8'h80;
        repeat (BYTE_CYC) tick;
        check("q_rdy_reload", 32'(data_ready), 32'd0);
        check("q_busy_reload", 32'(busy), 32'd1);
        data_valid = 1'b0;
        wait_stream("queue");
        check_words("queue", 16'hAA55, 16'h2552, 16'h4AAA, 3);
        check("q_rdy_end", 32'(data_ready), 32'd1);

        // reset on cell 7 with a second byte held
        cap_start;
        send_byte(8'hFF, 1'b0, wt);
        send_byte(8'h00, 1'b0, wt);
        n = 0;
        while (!busy && n < 20) begin
            tick;
            n++;
        end
        repeat (7 * CC + 2) tick;
        check("pre_rst_mfm", 32'(mfm_out), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_mfm", 32'(mfm_out), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rdy", 32'(data_ready), 32'd1);
        cap_en = 1'b0;
        tick;
        tick;
        reset_n = 1'b1;
        tick;
        cap_start;
        send_byte(8'h00, 1'b0, wt);
        wait_stream("rst_b00");
        check_words("rst_b00", 16'hAAAA, 16'h0, 16'h0, 1);

        // previous bit retained across an idle gap
        cap_start;
        send_byte(8'h01, 1'b0, wt);
        wait_stream("gap1");
        check_words("gap1", 16'hAAA9, 16'h0, 16'h0, 1);
        idle_ok = 1'b1;
        repeat (100) begin
            tick;
            if (busy || mfm_out || !data_ready) idle_ok = 1'b0;
        end
        check("gap_idle", 32'(idle_ok), 32'd1);
        cap_start;
        send_byte(8'h00, 1'b0, wt);
        wait_stream("gap2");
        check_words("gap2", 16'h2AAA, 16'h0, 16'h0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
